// File: rtl/pb_debounce_multi_if.sv
`default_nettype none
// ============================================================================
// pb_debounce_multi_if : pad/enable inputs and conditioned button outputs
// Rev 1.0 - initial release
// ============================================================================
interface pb_debounce_multi_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] pb_in;
   logic [N_CH-1:0] ch_en;
   logic [N_CH-1:0] pb_level;
   logic [N_CH-1:0] pb_press;
   logic [N_CH-1:0] pb_release;
   logic [N_CH-1:0] pb_hold;
   logic [N_CH-1:0] pb_repeat;

   modport master (
      output pb_in, ch_en,
      input  pb_level, pb_press, pb_release, pb_hold, pb_repeat
   );

   modport slave (
      input  pb_in, ch_en,
      output pb_level, pb_press, pb_release, pb_hold, pb_repeat
   );
endinterface
`default_nettype wire

// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// pb_debounce_multi : per-channel sync, tick-based debounce, press/release/
//                     hold/repeat pulse generation with a shared prescaler
// Rev 1.0 - initial release
// ============================================================================
module pb_debounce_multi #(
   parameter int N_CH         = 4,
   parameter int ACTIVE_LOW   = 1,
   parameter int SAMPLE_DIV   = 1000,
   parameter int STABLE_TICKS = 4,
   parameter int HOLD_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pb_debounce_multi_if.slave pb
);
   localparam int C_PW   = $clog2(SAMPLE_DIV + 1);
   localparam int C_SW   = $clog2(STABLE_TICKS + 1);
   localparam int C_HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int C_HW   = $clog2(C_HMAX + 1);
   localparam logic [N_CH-1:0] C_REL = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } hold_st_t;

   logic [C_PW-1:0] pcnt_q, pcnt_d;
   logic            tick;

   always_comb begin
      tick   = (pcnt_q == C_PW'(SAMPLE_DIV - 1));
      pcnt_d = tick ? '0 : pcnt_q + C_PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
   end

   // Synchroniser resets to the released pad level so reset never looks like a press.
   logic [N_CH-1:0] sync1_q, sync2_q, act;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= C_REL;
         sync2_q <= C_REL;
      end else begin
         sync1_q <= pb.pb_in;
         sync2_q <= sync1_q;
      end
   end

   assign act = sync2_q ^ C_REL;

   logic [N_CH-1:0] level_v, press_v, release_v, hold_v, repeat_v;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [C_SW-1:0] scnt_q, scnt_d;
      logic            level_q, level_d;
      logic            press_q, press_d;
      logic            rel_q, rel_d;
      logic            changed;
      hold_st_t        st_q;
      logic [C_HW-1:0] hcnt_q;
      logic            hold_q, rep_q;

      always_comb begin
         scnt_d  = scnt_q;
         level_d = level_q;
         changed = 1'b0;
         if (!pb.ch_en[i]) begin
            scnt_d  = '0;
            level_d = 1'b0;
         end else if (tick) begin
            if (act[i] != level_q) begin
               if (scnt_q + C_SW'(1) == C_SW'(STABLE_TICKS)) begin
                  level_d = act[i];
                  scnt_d  = '0;
                  changed = 1'b1;
               end else begin
                  scnt_d = scnt_q + C_SW'(1);
               end
            end else begin
               scnt_d = '0;
            end
         end
         press_d = changed & level_d;
         rel_d   = changed & ~level_d;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            scnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            scnt_q  <= scnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      // A level change owns its tick, so release beats a coincident hold/repeat expiry.
      always_ff @(posedge clk) begin
         if (rst) begin
            st_q   <= ST_IDLE;
            hcnt_q <= '0;
            hold_q <= 1'b0;
            rep_q  <= 1'b0;
         end else begin
            hold_q <= 1'b0;
            rep_q  <= 1'b0;
            if (!pb.ch_en[i]) begin
               st_q   <= ST_IDLE;
               hcnt_q <= '0;
            end else if (changed) begin
               st_q   <= level_d ? ST_PRESSED : ST_IDLE;
               hcnt_q <= '0;
            end else if (tick) begin
               case (st_q)
                  ST_PRESSED: begin
                     if (hcnt_q + C_HW'(1) == C_HW'(HOLD_TICKS)) begin
                        hold_q <= 1'b1;
                        st_q   <= ST_HELD;
                        hcnt_q <= '0;
                     end else begin
                        hcnt_q <= hcnt_q + C_HW'(1);
                     end
                  end
                  ST_HELD: begin
                     if (REPEAT_TICKS > 0) begin
                        if (hcnt_q + C_HW'(1) == C_HW'(REPEAT_TICKS)) begin
                           rep_q  <= 1'b1;
                           hcnt_q <= '0;
                        end else begin
                           hcnt_q <= hcnt_q + C_HW'(1);
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end

      assign level_v[i]   = level_q;
      assign press_v[i]   = press_q;
      assign release_v[i] = rel_q;
      assign hold_v[i]    = hold_q;
      assign repeat_v[i]  = rep_q;
   end

   assign pb.pb_level   = level_v;
   assign pb.pb_press   = press_v;
   assign pb.pb_release = release_v;
   assign pb.pb_hold    = hold_v;
   assign pb.pb_repeat  = repeat_v;
endmodule
`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// tb_pb_debounce_multi : directed scenarios plus random pad/enable/reset
//                        traffic checked against a rule-level reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_pb_debounce_multi;
   localparam int N  = 4;
   localparam int ST = 4;
   localparam int HT = 8;
   localparam int RT = 3;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] pad;
   logic [N-1:0] en;

   always #5 clk = ~clk;

   pb_debounce_multi_if #(.N_CH(N)) ifa ();
   pb_debounce_multi_if #(.N_CH(N)) ifb ();

   assign ifa.pb_in = pad;
   assign ifa.ch_en = en;
   assign ifb.pb_in = pad;
   assign ifb.ch_en = en;

   pb_debounce_multi #(.N_CH(N), .ACTIVE_LOW(1), .SAMPLE_DIV(1), .STABLE_TICKS(ST),
                       .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut_a (
      .clk(clk), .rst(rst), .pb(ifa.slave));

   pb_debounce_multi #(.N_CH(N), .ACTIVE_LOW(1), .SAMPLE_DIV(5), .STABLE_TICKS(ST),
                       .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut_b (
      .clk(clk), .rst(rst), .pb(ifb.slave));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: instance 0 ticks every cycle, instance 1 every 5th.
   int m_pc [2];
   bit m_s1 [2][N];
   bit m_s2 [2][N];
   bit m_lvl [2][N];
   int m_run [2][N];
   bit m_pressed [2][N];
   int m_t [2][N];
   logic [N-1:0] e_lvl [2];
   logic [N-1:0] e_press [2];
   logic [N-1:0] e_rel [2];
   logic [N-1:0] e_hold [2];
   logic [N-1:0] e_rep [2];

   task automatic model_step(input int k, input int div);
      bit tk;
      bit a;
      bit chg;
      e_press[k] = '0; e_rel[k] = '0; e_hold[k] = '0; e_rep[k] = '0;
      if (rst) begin
         m_pc[k] = 0;
         for (int c = 0; c < N; c++) begin
            m_s1[k][c] = 1'b1; m_s2[k][c] = 1'b1;
            m_lvl[k][c] = 1'b0; m_run[k][c] = 0; m_pressed[k][c] = 1'b0; m_t[k][c] = 0;
         end
      end else begin
         tk = (m_pc[k] == div - 1);
         m_pc[k] = tk ? 0 : m_pc[k] + 1;
         for (int c = 0; c < N; c++) begin
            a = ~m_s2[k][c];
            m_s2[k][c] = m_s1[k][c];
            m_s1[k][c] = pad[c];
            if (!en[c]) begin
               m_lvl[k][c] = 1'b0; m_run[k][c] = 0; m_pressed[k][c] = 1'b0; m_t[k][c] = 0;
            end else if (tk) begin
               chg = 1'b0;
               if (a != m_lvl[k][c]) begin
                  m_run[k][c]++;
                  if (m_run[k][c] == ST) begin
                     m_lvl[k][c] = a; m_run[k][c] = 0; chg = 1'b1;
                  end
               end else begin
                  m_run[k][c] = 0;
               end
               if (chg) begin
                  if (m_lvl[k][c]) e_press[k][c] = 1'b1;
                  else             e_rel[k][c]   = 1'b1;
                  m_pressed[k][c] = m_lvl[k][c];
                  m_t[k][c] = 0;
               end else if (m_pressed[k][c]) begin
                  m_t[k][c]++;
                  if (m_t[k][c] == HT) e_hold[k][c] = 1'b1;
                  else if (RT > 0 && m_t[k][c] > HT && (m_t[k][c] - HT) % RT == 0) e_rep[k][c] = 1'b1;
               end
            end
         end
      end
      for (int c = 0; c < N; c++) e_lvl[k][c] = m_lvl[k][c];
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0, 1);
      model_step(1, 5);
      @(negedge clk);
      check_eq("a_level",   ifa.pb_level,   e_lvl[0]);
      check_eq("a_press",   ifa.pb_press,   e_press[0]);
      check_eq("a_release", ifa.pb_release, e_rel[0]);
      check_eq("a_hold",    ifa.pb_hold,    e_hold[0]);
      check_eq("a_repeat",  ifa.pb_repeat,  e_rep[0]);
      check_eq("b_level",   ifb.pb_level,   e_lvl[1]);
      check_eq("b_press",   ifb.pb_press,   e_press[1]);
      check_eq("b_release", ifb.pb_release, e_rel[1]);
      check_eq("b_hold",    ifb.pb_hold,    e_hold[1]);
      check_eq("b_repeat",  ifb.pb_repeat,  e_rep[1]);
   endtask

   int lat_a, lat_b, n, others, hold_at, rel_at, nrep, late_rep, nhold;
   logic [N-1:0] tgt;
   int age [N];

   initial begin
      rst = 1'b1; pad = '1; en = '1;
      repeat (3) cycle();
      check_eq("reset_outputs_a", {ifa.pb_level, ifa.pb_press, ifa.pb_release, ifa.pb_hold, ifa.pb_repeat}, 0);
      rst = 1'b0;
      cycle();

      // Single press on ch0, latency on both prescaler settings.
      pad[0] = 1'b0; lat_a = -1; lat_b = -1; n = 0; others = 0;
      for (int i = 1; i <= 25; i++) begin
         cycle();
         if (ifa.pb_level[0] && lat_a < 0) lat_a = i;
         if (ifb.pb_level[0] && lat_b < 0) lat_b = i;
         if (ifa.pb_press[0]) n++;
         if (ifa.pb_level[3:1] != 3'b000) others++;
      end
      check_eq("t1_latency", lat_a, 6);
      check_eq("t1_press_count", n, 1);
      check_eq("t1_other_channels", others, 0);
      check_eq("t6_latency_window", 32'(lat_b >= 18 && lat_b <= 22), 1);

      // Disable clears level silently; re-enable re-qualifies.
      en[0] = 1'b0;
      cycle();
      check_eq("t6_disable_level", {ifa.pb_level[0], ifb.pb_level[0]}, 0);
      check_eq("t6_disable_no_release", {ifa.pb_release[0], ifb.pb_release[0]}, 0);
      en[0] = 1'b1; lat_a = -1;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         if (ifa.pb_level[0] && lat_a < 0) lat_a = i;
      end
      check_eq("t6_requalify_latency", lat_a, ST);
      pad[0] = 1'b1;
      repeat (30) cycle();

      // Bouncing ch1.
      n = 0;
      for (int b = 0; b < 4; b++) begin
         pad[1] = (b % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) begin
            cycle();
            if (ifa.pb_press[1]) n++;
         end
      end
      pad[1] = 1'b0; lat_a = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         if (ifa.pb_press[1]) begin
            n++;
            if (lat_a < 0) lat_a = i;
         end
      end
      check_eq("t2_press_count", n, 1);
      check_eq("t2_latency", lat_a, 6);
      pad[1] = 1'b1;
      repeat (12) cycle();

      // Long hold on ch2 with repeats, then release.
      pad[2] = 1'b0; hold_at = -1; rel_at = -1; nrep = 0; late_rep = 0; n = 0;
      for (int i = 1; i <= 50; i++) begin
         if (i == 31) pad[2] = 1'b1;
         cycle();
         if (ifa.pb_hold[2] && hold_at < 0) hold_at = i;
         if (ifa.pb_repeat[2]) begin
            nrep++;
            if (rel_at >= 0) late_rep++;
         end
         if (ifa.pb_release[2]) begin
            n++;
            if (rel_at < 0) rel_at = i;
         end
      end
      check_eq("t3_hold_cycle", hold_at, 14);
      check_eq("t3_repeat_count", nrep, 7);
      check_eq("t3_release_count", n, 1);
      check_eq("t3_release_cycle", rel_at, 36);
      check_eq("t3_repeat_after_release", late_rep, 0);

      // ch3 released exactly on the hold-expiry tick.
      pad[3] = 1'b0; rel_at = -1; nhold = 0;
      for (int i = 1; i <= 25; i++) begin
         if (i == 9) pad[3] = 1'b1;
         cycle();
         if (ifa.pb_hold[3]) nhold++;
         if (ifa.pb_release[3] && rel_at < 0) rel_at = i;
      end
      check_eq("t4_release_cycle", rel_at, 14);
      check_eq("t4_hold_suppressed", nhold, 0);

      // Reset mid-hold with the pad still pressed.
      pad[0] = 1'b0;
      repeat (20) cycle();
      rst = 1'b1;
      cycle();
      check_eq("t5_reset_outputs", {ifa.pb_level, ifa.pb_press, ifa.pb_release, ifa.pb_hold, ifa.pb_repeat}, 0);
      rst = 1'b0; n = 0;
      for (int i = 1; i <= 5; i++) begin
         cycle();
         if (|{ifa.pb_press, ifa.pb_release, ifa.pb_hold, ifa.pb_repeat}) n++;
      end
      check_eq("t5_quiet_after_reset", n, 0);
      cycle();
      check_eq("t5_press_after_reset", ifa.pb_press, 4'b0001);
      pad[0] = 1'b1;
      repeat (10) cycle();

      // Random bouncy traffic with occasional enable toggles and resets.
      tgt = pad;
      for (int c = 0; c < N; c++) age[c] = 100;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 89) == 0) begin
               tgt[c] = ~tgt[c];
               age[c] = 0;
            end else begin
               age[c]++;
            end
            pad[c] = (age[c] < 8 && $urandom_range(0, 2) == 0) ? ~tgt[c] : tgt[c];
            if ($urandom_range(0, 299) == 0) en[c] = ~en[c];
         end
         rst = ($urandom_range(0, 1499) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
